multicycle_controller: RTL and testbench

Moore/Mealy control FSM that sequences the shared multicycle RV32 datapath (IFU, immediate generator, register file, ALU, single unified memory port).
- Issues fetch and data-memory requests over a request/ready handshake.
- Steers immediate type, ALU operand/op and writeback selects, and PC update.
- Supports exactly: R-type (0110011), ANDI/OP-IMM (0010011), LH (0000011), SH (0100011), BEQ (1100011).

---
 rtl/multicycle_controller_if.sv | 10 +
 rtl/multicycle_controller.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Request/ready handshake between the multicycle controller and the unified memory port.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM sequencing the shared multicycle RV32 datapath (R-type, OP-IMM, LH, SH, BEQ).
// Optional feature macro ILLEGAL_TRAP_EN: unknown opcodes trap to HALT instead of acting as NOPs.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_controller_if.master        mem,
  input  logic [6:0]                     opcode,
  input  logic                           zero,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic                           pc_src,
  output logic [1:0]                     imm_type,
  output logic [1:0]                     alu_src_b,
  output logic [1:0]                     alu_op,
  output logic                           reg_write,
  output logic                           wb_sel,
  output logic                           instr_retired,
  output logic                           mem_err,
  output logic                           illegal,
  output logic [2:0]                     state
);

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERROR  = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [6:0]      OP_R     = 7'b0110011;
  localparam logic [6:0]      OP_IMM   = 7'b0010011;
  localparam logic [6:0]      OP_LH    = 7'b0000011;
  localparam logic [6:0]      OP_SH    = 7'b0100011;
  localparam logic [6:0]      OP_BEQ   = 7'b1100011;
  localparam logic [TO_W-1:0] LIMIT_C  = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] ONE_C    = TO_W'(1);

  state_e          state_r;
  state_e          state_nxt_s;
  logic [TO_W-1:0] wait_cnt_r;
  logic            mem_err_r;
  logic            is_r_s, is_imm_s, is_lh_s, is_sh_s, is_beq_s, supported_s;
  logic            waiting_s, timeout_s;

  assign is_r_s      = (opcode == OP_R);
  assign is_imm_s    = (opcode == OP_IMM);
  assign is_lh_s     = (opcode == OP_LH);
  assign is_sh_s     = (opcode == OP_SH);
  assign is_beq_s    = (opcode == OP_BEQ);
  assign supported_s = is_r_s | is_imm_s | is_lh_s | is_sh_s | is_beq_s;

  // Ready in the limit cycle still completes; only a stalled limit cycle times out.
  assign waiting_s = ((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem.mem_ready;
  assign timeout_s = waiting_s && (wait_cnt_r == LIMIT_C);

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_START:  state_nxt_s = ST_FETCH;
      ST_FETCH: begin
        if (mem.mem_ready)  state_nxt_s = ST_DECODE;
        else if (timeout_s) state_nxt_s = ST_ERROR;
        else                state_nxt_s = ST_FETCH;
      end
      ST_DECODE: begin
        if (supported_s) state_nxt_s = ST_EXEC;
`ifdef ILLEGAL_TRAP_EN
        else             state_nxt_s = ST_HALT;
`else
        else             state_nxt_s = ST_FETCH;
`endif
      end
      ST_EXEC: begin
        if (is_r_s || is_imm_s)      state_nxt_s = ST_WB;
        else if (is_lh_s || is_sh_s) state_nxt_s = ST_MEM;
        else                         state_nxt_s = ST_FETCH;
      end
      ST_MEM: begin
        if (mem.mem_ready)  state_nxt_s = is_sh_s ? ST_FETCH : ST_WB;
        else if (timeout_s) state_nxt_s = ST_ERROR;
        else                state_nxt_s = ST_MEM;
      end
      ST_WB:     state_nxt_s = ST_FETCH;
      ST_ERROR:  state_nxt_s = ST_ERROR;
      ST_HALT:   state_nxt_s = ST_HALT;
      default:   state_nxt_s = ST_START;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_r;
  assign illegal = illegal_r;
`else
  assign illegal = 1'b0;
`endif

  // State register, memory wait counter and sticky fault flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_START;
      wait_cnt_r <= '0;
      mem_err_r  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) wait_cnt_r <= '0;
      else if (waiting_s)         wait_cnt_r <= wait_cnt_r + ONE_C;
      else                        wait_cnt_r <= wait_cnt_r;
      if (state_nxt_s == ST_ERROR) mem_err_r <= 1'b1;
      else                         mem_err_r <= mem_err_r;
`ifdef ILLEGAL_TRAP_EN
      if (state_nxt_s == ST_HALT) illegal_r <= 1'b1;
      else                        illegal_r <= illegal_r;
`endif
    end
  end

  assign state   = state_r;
  assign mem_err = mem_err_r;

  // Strobe decode from the state plus opcode, zero and mem_ready.
  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 1'b0;
    imm_type         = 2'b00;
    alu_src_b        = 2'b00;
    alu_op           = 2'b00;
    reg_write        = 1'b0;
    wb_sel           = 1'b0;
    instr_retired    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end else begin
          ir_write = 1'b0;
          pc_write = 1'b0;
        end
      end
      ST_DECODE: begin
        if (is_sh_s)       imm_type = 2'b01;
        else if (is_beq_s) imm_type = 2'b10;
        else               imm_type = 2'b00;
      end
      ST_EXEC, ST_WB: begin
        if (is_r_s) begin
          alu_op = 2'b10;
        end else if (is_imm_s) begin
          alu_op    = 2'b10;
          alu_src_b = 2'b01;
        end else if (is_lh_s || is_sh_s) begin
          alu_src_b = 2'b01;
        end else if (is_beq_s) begin
          alu_op = 2'b01;
        end else begin
          alu_op = 2'b00;
        end
        if (state_r == ST_WB) begin
          reg_write     = 1'b1;
          wb_sel        = is_lh_s;
          instr_retired = 1'b1;
        end else if (is_beq_s) begin
          instr_retired = 1'b1;
          pc_write      = zero;
          pc_src        = zero;
        end else begin
          instr_retired = 1'b0;
        end
      end
      ST_MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = is_sh_s;
        alu_src_b        = 2'b01;
        instr_retired    = is_sh_s & mem.mem_ready;
      end
      default: begin
        mem.mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench: a memory responder feeds instructions, a monitor
// slices the output stream into per-instruction records and compares them to a spec-level model.
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LH  = 7'b0000011;
  localparam logic [6:0] OP_SH  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       ir_write, pc_write, pc_src, reg_write, wb_sel, instr_retired, mem_err, illegal;
  logic [1:0] imm_type, alu_src_b, alu_op;
  logic [2:0] state;

  multicycle_controller_if bus ();

  multicycle_controller #(.MEM_TIMEOUT(15), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem(bus), .opcode(opcode), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .imm_type(imm_type),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .instr_retired(instr_retired), .mem_err(mem_err), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { logic [6:0] op; bit z; int fw; int mw; } instr_t;
  typedef struct {
    int cycles; int retire; int regw; int wbsel; int memwe; int pcw; int taken; int irw;
    int imm; int aop; int asb; bit has_exec;
  } rec_t;

  instr_t prog_q[$];
  rec_t   exp_q[$];
  instr_t cur;
  bit     mon_en = 1'b0;
  int     n_chk = 0;
  int     n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit is_sup(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LH) || (op == OP_SH) || (op == OP_BEQ);
  endfunction

  // Reference model: what one instruction looks like from fetch start to the next fetch start.
  function automatic rec_t model(input instr_t i);
    rec_t e;
    e.cycles = 2 + i.fw; e.retire = 0; e.regw = 0; e.wbsel = 0; e.memwe = 0;
    e.pcw = 1; e.taken = 0; e.irw = 1; e.imm = 0; e.aop = 0; e.asb = 0; e.has_exec = 1'b0;
    if (i.op == OP_R || i.op == OP_IMM) begin
      e.cycles = 4 + i.fw; e.retire = 1; e.regw = 1; e.aop = 2;
      e.asb = (i.op == OP_IMM) ? 1 : 0; e.has_exec = 1'b1;
    end else if (i.op == OP_LH) begin
      e.cycles = 5 + i.fw + i.mw; e.retire = 1; e.regw = 1; e.wbsel = 1; e.asb = 1; e.has_exec = 1'b1;
    end else if (i.op == OP_SH) begin
      e.cycles = 4 + i.fw + i.mw; e.retire = 1; e.memwe = i.mw + 1; e.imm = 1; e.asb = 1; e.has_exec = 1'b1;
    end else if (i.op == OP_BEQ) begin
      e.cycles = 3 + i.fw; e.retire = 1; e.taken = i.z ? 1 : 0; e.pcw = 1 + e.taken;
      e.imm = 2; e.aop = 1; e.has_exec = 1'b1;
    end
    return e;
  endfunction

  task automatic issue(input logic [6:0] op, input bit z, input int fw, input int mw);
    instr_t i;
    i.op = op; i.z = z; i.fw = fw; i.mw = mw;
    prog_q.push_back(i);
    exp_q.push_back(model(i));
  endtask

  // Memory responder: answers each request after the scheduled number of wait cycles.
  initial begin : responder
    int  wcnt;
    int  target;
    bit  have;
    bit  fetch_hs;
    bus.mem_ready = 1'b0; opcode = 7'd0; zero = 1'b0; wcnt = 0;
    forever begin
      @(negedge clk);
      fetch_hs = 1'b0;
      if (!rst_n) begin
        bus.mem_ready = 1'b0; wcnt = 0;
      end else if (bus.mem_req) begin
        if (!bus.mem_addr_sel) begin
          have = (prog_q.size() > 0); target = have ? prog_q[0].fw : 0;
        end else begin
          have = 1'b1; target = cur.mw;
        end
        if (have && wcnt >= target) begin
          bus.mem_ready = 1'b1; wcnt = 0; fetch_hs = !bus.mem_addr_sel;
        end else begin
          bus.mem_ready = 1'b0; wcnt++;
        end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        wcnt = 0;
      end
      @(posedge clk); #1;
      if (rst_n && fetch_hs && prog_q.size() > 0) begin
        cur = prog_q.pop_front(); opcode = cur.op; zero = cur.z;
      end
    end
  end

  // Monitor: one record per instruction, closed at the next fetch start.
  initial begin : monitor
    bit   prev_fetch, prev_ready, in_rec, fetch_now;
    int   since_ir, rec_no;
    rec_t o, e;
    prev_fetch = 1'b0; prev_ready = 1'b0; in_rec = 1'b0; since_ir = -1; rec_no = 0;
    o = '{default: 0};
    forever begin
      @(negedge clk); #1;
      if (!mon_en || !rst_n) begin
        in_rec = 1'b0; prev_fetch = 1'b0; prev_ready = 1'b0;
      end else begin
        fetch_now = bus.mem_req && !bus.mem_addr_sel;
        if (fetch_now && !(prev_fetch && !prev_ready)) begin
          if (in_rec) begin
            if (exp_q.size() == 0) chk($sformatf("unexpected_instr[%0d]", rec_no), 1, 0);
            else begin
              e = exp_q.pop_front();
              chk($sformatf("cycles[%0d]", rec_no), o.cycles, e.cycles);
              chk($sformatf("retire[%0d]", rec_no), o.retire, e.retire);
              chk($sformatf("reg_write[%0d]", rec_no), o.regw, e.regw);
              chk($sformatf("wb_sel[%0d]", rec_no), o.wbsel, e.wbsel);
              chk($sformatf("mem_we[%0d]", rec_no), o.memwe, e.memwe);
              chk($sformatf("pc_write[%0d]", rec_no), o.pcw, e.pcw);
              chk($sformatf("branch_taken[%0d]", rec_no), o.taken, e.taken);
              chk($sformatf("ir_write[%0d]", rec_no), o.irw, e.irw);
              chk($sformatf("imm_type[%0d]", rec_no), o.imm, e.imm);
              if (e.has_exec) begin
                chk($sformatf("alu_op[%0d]", rec_no), o.aop, e.aop);
                chk($sformatf("alu_src_b[%0d]", rec_no), o.asb, e.asb);
              end
            end
            rec_no++;
          end
          o = '{default: 0}; since_ir = -1; in_rec = 1'b1;
        end
        if (in_rec) begin
          o.cycles++;
          if (instr_retired)        o.retire++;
          if (reg_write)            o.regw++;
          if (reg_write && wb_sel)  o.wbsel++;
          if (bus.mem_we)           o.memwe++;
          if (pc_write)             o.pcw++;
          if (pc_write && pc_src)   o.taken++;
          if (ir_write)             o.irw++;
          if (ir_write)             since_ir = 0;
          else if (since_ir >= 0)   since_ir++;
          if (since_ir == 1) o.imm = int'(imm_type);
          if (since_ir == 2) begin o.aop = int'(alu_op); o.asb = int'(alu_src_b); end
        end
        prev_fetch = fetch_now; prev_ready = bus.mem_ready;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    int         exp_states [6];
    int         st [6];
    int         nreq, ret, nk, k;
    bit         seen;
    logic [6:0] op;
    exp_states = '{0, 1, 2, 3, 5, 1};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", state, 0);
    chk("reset_mem_req", bus.mem_req, 0);
    chk("reset_ir_write", ir_write, 0);
    chk("reset_pc_write", pc_write, 0);
    chk("reset_retired", instr_retired, 0);
    chk("reset_mem_err", mem_err, 0);
    chk("reset_illegal", illegal, 0);

    issue(OP_R, 1'b0, 0, 0);
    issue(OP_LH, 1'b0, 0, 3);
    issue(OP_SH, 1'b0, 0, 0);
    issue(OP_BEQ, 1'b1, 0, 0);
    issue(OP_BEQ, 1'b0, 0, 0);
    issue(OP_IMM, 1'b0, 15, 0);
    issue(OP_LH, 1'b0, 2, 15);
    issue(OP_SH, 1'b0, 15, 15);
`ifdef ILLEGAL_TRAP_EN
    nk = 5;
`else
    issue(7'h7F, 1'b0, 0, 0);
    nk = 6;
`endif
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, nk - 1);
      case (k)
        0: op = OP_R;
        1: op = OP_IMM;
        2: op = OP_LH;
        3: op = OP_SH;
        4: op = OP_BEQ;
        default: begin
          op = 7'($urandom_range(0, 127));
          while (is_sup(op)) op = 7'($urandom_range(0, 127));
        end
      endcase
      issue(op, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    mon_en = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("add_state_trace[%0d]", i), state, exp_states[i]);
      @(negedge clk); #1;
    end
    for (int c = 0; c < 4000 && exp_q.size() != 0; c++) @(negedge clk);
    chk("program_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Fetch never answered: times out into ERROR.
    rst_n = 1'b0; prog_q.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    nreq = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk); #1;
      if (state == 3'd6) seen = 1'b1;
      else if (bus.mem_req) nreq++;
    end
    chk("timeout_reached", seen, 1);
    chk("timeout_fetch_cycles", nreq, 16);
    chk("error_mem_err", mem_err, 1);
    chk("error_mem_req", bus.mem_req, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("error_held_state", state, 6);
    chk("error_held_mem_err", mem_err, 1);
    chk("error_held_mem_req", bus.mem_req, 0);

    // Reset asserted in the middle of a stalled MEM request.
    rst_n = 1'b0; prog_q.delete();
    issue(OP_LH, 1'b0, 0, 12);
    void'(exp_q.pop_back());
    @(negedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #1;
      if (bus.mem_req && bus.mem_addr_sel) seen = 1'b1;
    end
    chk("mid_mem_reached", seen, 1);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_mem_req", bus.mem_req, 0);
    chk("async_reset_state", state, 0);
    chk("async_reset_mem_err", mem_err, 0);

    // Unknown opcode 0x7F.
    prog_q.delete();
    issue(7'h7F, 1'b0, 0, 0);
    void'(exp_q.pop_back());
    @(negedge clk); #1;
    rst_n = 1'b1;
    ret = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      st[i] = int'(state);
      ret += int'(instr_retired);
    end
    chk("illegal_decode_state", st[1], 2);
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_halt_state", st[3], 7);
    chk("illegal_halt_held", st[5], 7);
    chk("illegal_flag", illegal, 1);
    chk("illegal_mem_req", bus.mem_req, 0);
`else
    chk("nop_refetch_state", st[2], 1);
    chk("nop_fetch_held", st[5], 1);
    chk("nop_illegal_flag", illegal, 0);
    chk("nop_mem_req", bus.mem_req, 1);
`endif
    chk("illegal_no_retire", ret, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
